// File: rtl/data_mem_unit.sv
// Data-memory stage: word RAM with byte/half/word stores plus a 16-byte MMIO window.
// Latency: reads are combinational (0 cycles); stores and register updates commit on the rising clk edge.
// Backpressure: none, every access completes in its own cycle; faulting stores are dropped and flagged in err.
module data_mem_unit #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h0000_FF00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [15:0] sw_in,
    output logic [31:0] rdata,
    output logic [15:0] led,
    output logic [1:0]  err
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;

    localparam logic [1:0] OFF_LED    = 2'd0;
    localparam logic [1:0] OFF_SW     = 2'd1;
    localparam logic [1:0] OFF_CNT    = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    logic [31:0] mem_q [DEPTH];

    logic [15:0] led_q, led_d;
    logic [15:0] sw_meta_q, sw_sync_q;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  err_q, err_d;

    logic          is_mmio, is_ram, is_oor;
    logic          aligned;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [AW-1:0] ram_idx;
    logic [1:0]    mmio_off;
    logic          wr_en, rd_en, ram_we, mmio_we;
    logic [31:0]   ram_rdata, mmio_rdata;
    logic [1:0]    err_set, err_clr;

    // MMIO takes priority over RAM so the window can sit anywhere in the address map.
    assign is_mmio  = (addr[31:4] == MMIO_BASE[31:4]);
    assign is_ram   = !is_mmio && (addr < RAM_BYTES);
    assign is_oor   = !is_mmio && !is_ram;
    assign ram_idx  = addr[AW+1:2];
    assign mmio_off = addr[3:2];

    assign wr_en   = cs & wr;
    assign rd_en   = cs & rd;
    // Gating with reset drops a store that coincides with reset assertion.
    assign ram_we  = wr_en & is_ram & aligned & ~reset;
    assign mmio_we = wr_en & is_mmio;

    // Byte-enable and lane replication for the store width; reserved size behaves as word.
    always_comb begin
        be      = 4'b1111;
        wlane   = wdata;
        aligned = (addr[1:0] == 2'b00);
        case (size)
            SZ_BYTE: begin
                be      = 4'b0001 << addr[1:0];
                wlane   = {4{wdata[7:0]}};
                aligned = 1'b1;
            end
            SZ_HALF: begin
                be      = addr[1] ? 4'b1100 : 4'b0011;
                wlane   = {2{wdata[15:0]}};
                aligned = ~addr[0];
            end
            default: ;
        endcase
    end

    // RAM lane writes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[ram_idx][8*i +: 8] <= wlane[8*i +: 8];
                end
            end
        end
    end

    // Right-align the addressed byte/half for the CPU's extraction logic, zero-filled.
    assign ram_rdata = mem_q[ram_idx] >> {addr[1:0], 3'b000};

    // MMIO register read mux.
    always_comb begin
        mmio_rdata = 32'd0;
        case (mmio_off)
            OFF_LED:    mmio_rdata = {16'd0, led_q};
            OFF_SW:     mmio_rdata = {16'd0, sw_sync_q};
            OFF_CNT:    mmio_rdata = cnt_q;
            OFF_STATUS: mmio_rdata = {30'd0, err_q};
            default:    mmio_rdata = 32'd0;
        endcase
    end

    // Final read data: only driven for an active read to a decoded region.
    always_comb begin
        rdata = 32'd0;
        if (rd_en) begin
            if (is_mmio) begin
                rdata = mmio_rdata;
            end else if (is_ram) begin
                rdata = ram_rdata;
            end
        end
    end

    // Next-state for LED, counter and sticky status; a new error event beats a W1C clear.
    always_comb begin
        led_d = led_q;
        if (mmio_we && (mmio_off == OFF_LED)) begin
            led_d = wdata[15:0];
        end

        cnt_d = cnt_q + 32'd1;
        if (mmio_we && (mmio_off == OFF_CNT)) begin
            cnt_d = 32'd0;
        end

        err_clr = 2'b00;
        if (mmio_we && (mmio_off == OFF_STATUS)) begin
            err_clr = wdata[1:0];
        end
        err_set[0] = wr_en & is_ram & ~aligned;
        err_set[1] = (wr_en | rd_en) & is_oor;
        err_d      = (err_q & ~err_clr) | err_set;
    end

    // I/O registers and switch synchroniser, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q     <= 16'd0;
            sw_meta_q <= 16'd0;
            sw_sync_q <= 16'd0;
            cnt_q     <= 32'd0;
            err_q     <= 2'b00;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign led = led_q;
    assign err = err_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Testbench for data_mem_unit: byte-array reference model, randomized and directed scenarios.
// Latency: inputs driven after negedge, combinational reads sampled 1 time unit later.
// Backpressure: not applicable; every operation completes in one cycle.
module tb_data_mem_unit;

    localparam int          DEPTH = 64;
    localparam logic [31:0] MB    = 32'h0000_FF00;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, rd, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [15:0] sw_in;
    logic [31:0] rdata;
    logic [15:0] led;
    logic [1:0]  err;

    int nchecks = 0;
    int nerrs   = 0;

    logic [7:0]  ref_mem [DEPTH*4];
    logic [15:0] ref_led;
    logic [1:0]  ref_err;

    data_mem_unit #(.DEPTH(DEPTH), .MMIO_BASE(MB)) dut (
        .clk(clk), .reset(reset), .cs(cs), .rd(rd), .wr(wr), .size(size),
        .addr(addr), .wdata(wdata), .sw_in(sw_in), .rdata(rdata),
        .led(led), .err(err)
    );

    always #5 clk = ~clk;

    // Reference store: byte array, width from size, alignment = address multiple of width.
    function automatic void model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        int n;
        n = (s == 2'b01) ? 1 : (s == 2'b10) ? 2 : 4;
        if (a[31:4] == MB[31:4]) begin
            if (a[3:2] == 2'd0) ref_led = d[15:0];
            if (a[3:2] == 2'd3) ref_err = ref_err & ~d[1:0];
        end else if (a < DEPTH*4) begin
            if ((a % n) != 0) ref_err[0] = 1'b1;
            else for (int k = 0; k < n; k++) ref_mem[a + k] = d[8*k +: 8];
        end else begin
            ref_err[1] = 1'b1;
        end
    endfunction

    function automatic logic [31:0] model_ram_read(input logic [31:0] a);
        logic [31:0] base, w;
        if (a >= DEPTH*4) return 32'd0;
        base = a & ~32'd3;
        w = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
        return w >> (8 * (a % 4));
    endfunction

    task automatic wr_op(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; wdata = d; size = s;
        @(posedge clk);
        model_store(a, d, s);
        #1;
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_op(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
        #1;
        v = rdata;
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        nchecks++; if (led !== 16'd0) begin nerrs++; $display("FAIL reset_led: got %h want 0000", led); end
        nchecks++; if (err !== 2'b00) begin nerrs++; $display("FAIL reset_err: got %b want 00", err); end
        nchecks++; if (rdata !== 32'd0) begin nerrs++; $display("FAIL reset_rdata_idle: got %h want 0", rdata); end
        rd_op(MB + 8, v);
        nchecks++; if (v !== 32'd0) begin nerrs++; $display("FAIL reset_cnt: got %h want 0", v); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] a, d, v;
        logic [1:0]  s;
        for (int i = 0; i < DEPTH; i++) wr_op(32'(i * 4), $urandom, 2'b00);
        for (int i = 0; i < 60; i++) begin
            a = $urandom_range(0, DEPTH*4 - 1);
            s = 2'($urandom_range(0, 3));
            d = $urandom;
            wr_op(a, d, s);
            nchecks++; if (err !== ref_err) begin nerrs++; $display("FAIL rand_err[%0d]: got %b want %b", i, err, ref_err); end
            a = (a & ~32'd3) | 32'($urandom_range(0, 3));
            rd_op(a, v);
            nchecks++; if (v !== model_ram_read(a)) begin nerrs++; $display("FAIL rand_rd[%0d] @%h: got %h want %h", i, a, v, model_ram_read(a)); end
        end
        wr_op(MB + 12, 32'h3, 2'b00);
        nchecks++; if (err !== 2'b00) begin nerrs++; $display("FAIL rand_clr: got %b want 00", err); end
    endtask

    task automatic test_stores();
        logic [31:0] v, prev;
        wr_op(32'h10, 32'hDEADBEEF, 2'b00);
        rd_op(32'h13, v);
        nchecks++; if (v !== 32'h000000DE) begin nerrs++; $display("FAIL byte_rd_13: got %h want 000000de", v); end
        rd_op(32'h12, v);
        nchecks++; if (v !== 32'h0000DEAD) begin nerrs++; $display("FAIL half_rd_12: got %h want 0000dead", v); end
        wr_op(32'h10, 32'h11223344, 2'b00);
        wr_op(32'h11, 32'hFFFFFF5A, 2'b01);
        rd_op(32'h10, v);
        nchecks++; if (v !== 32'h11225A44) begin nerrs++; $display("FAIL byte_store: got %h want 11225a44", v); end
        wr_op(32'h12, 32'h1234BEEF, 2'b10);
        rd_op(32'h10, v);
        nchecks++; if (v !== 32'hBEEF5A44) begin nerrs++; $display("FAIL half_store: got %h want beef5a44", v); end
        prev = model_ram_read(32'h20);
        wr_op(32'h21, 32'hFFFF, 2'b10);
        rd_op(32'h20, v);
        nchecks++; if (v !== prev) begin nerrs++; $display("FAIL misalign_ram: got %h want %h", v, prev); end
        nchecks++; if (err !== 2'b01) begin nerrs++; $display("FAIL misalign_err: got %b want 01", err); end
        wr_op(MB + 12, 32'h1, 2'b00);
        nchecks++; if (err !== 2'b00) begin nerrs++; $display("FAIL w1c_clear: got %b want 00", err); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] v, prev;
        prev = model_ram_read(32'h0);
        wr_op(32'(DEPTH*4), 32'h12345678, 2'b00);
        nchecks++; if (err !== 2'b10) begin nerrs++; $display("FAIL oor_wr_err: got %b want 10", err); end
        rd_op(32'h0, v);
        nchecks++; if (v !== prev) begin nerrs++; $display("FAIL oor_no_alias: got %h want %h", v, prev); end
        rd_op(32'(DEPTH*4), v);
        nchecks++; if (v !== 32'd0) begin nerrs++; $display("FAIL oor_rd_zero: got %h want 0", v); end
        wr_op(MB + 12, 32'h1, 2'b00);
        nchecks++; if (err !== 2'b10) begin nerrs++; $display("FAIL w1c_other_bit: got %b want 10", err); end
        wr_op(MB + 12, 32'h2, 2'b00);
        nchecks++; if (err !== 2'b00) begin nerrs++; $display("FAIL w1c_bit1: got %b want 00", err); end
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = 32'h0000_0200;
        @(posedge clk);
        ref_err[1] = 1'b1;
        #1;
        cs = 1'b0; rd = 1'b0;
        nchecks++; if (err !== ref_err) begin nerrs++; $display("FAIL oor_rd_err: got %b want %b", err, ref_err); end
        wr_op(MB + 12, 32'h3, 2'b00);
    endtask

    task automatic test_rw_same_cycle();
        logic [31:0] old, v;
        old = model_ram_read(32'h40);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 32'h40; wdata = 32'hCAFEF00D; size = 2'b00;
        #1;
        nchecks++; if (rdata !== old) begin nerrs++; $display("FAIL rw_old: got %h want %h", rdata, old); end
        @(posedge clk);
        model_store(32'h40, 32'hCAFEF00D, 2'b00);
        #1;
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        rd_op(32'h40, v);
        nchecks++; if (v !== 32'hCAFEF00D) begin nerrs++; $display("FAIL rw_new: got %h want cafef00d", v); end
    endtask

    task automatic test_led_switch();
        logic [31:0] v;
        wr_op(MB, 32'h0000ABCD, 2'b00);
        nchecks++; if (led !== ref_led) begin nerrs++; $display("FAIL led_out: got %h want %h", led, ref_led); end
        rd_op(MB, v);
        nchecks++; if (v !== 32'h0000ABCD) begin nerrs++; $display("FAIL led_rd: got %h want 0000abcd", v); end
        @(negedge clk);
        sw_in = 16'h00F0; cs = 1'b1; rd = 1'b1; addr = MB + 4;
        #1;
        nchecks++; if (rdata !== 32'd0) begin nerrs++; $display("FAIL sw_0edge: got %h want 0", rdata); end
        @(negedge clk); #1;
        nchecks++; if (rdata !== 32'd0) begin nerrs++; $display("FAIL sw_1edge: got %h want 0", rdata); end
        @(negedge clk); #1;
        nchecks++; if (rdata !== 32'h000000F0) begin nerrs++; $display("FAIL sw_2edge: got %h want 000000f0", rdata); end
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic test_counter();
        wr_op(MB + 8, $urandom, 2'b00);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = MB + 8;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            nchecks++; if (rdata !== 32'(i)) begin nerrs++; $display("FAIL cnt_seq[%0d]: got %h want %h", i, rdata, 32'(i)); end
        end
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        cs = 1'b1; rd = 1'b1; addr = MB + 8;
        #1;
        nchecks++; if (rdata !== 32'hFFFF_FFFF) begin nerrs++; $display("FAIL wrap_max: got %h want ffffffff", rdata); end
        @(negedge clk); #1;
        nchecks++; if (rdata !== 32'd0) begin nerrs++; $display("FAIL wrap_zero: got %h want 0", rdata); end
        @(negedge clk); #1;
        nchecks++; if (rdata !== 32'd1) begin nerrs++; $display("FAIL wrap_one: got %h want 1", rdata); end
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic test_reset_midrun();
        logic [31:0] v, prev;
        wr_op(MB, 32'h0000_1234, 2'b00);
        wr_op(32'h21, 32'h0, 2'b10);
        nchecks++; if (led !== 16'h1234 || err !== 2'b01) begin nerrs++; $display("FAIL pre_reset: got led %h err %b want 1234 01", led, err); end
        prev = model_ram_read(32'h10);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        nchecks++; if (led !== 16'd0) begin nerrs++; $display("FAIL mid_reset_led: got %h want 0", led); end
        nchecks++; if (err !== 2'b00) begin nerrs++; $display("FAIL mid_reset_err: got %b want 00", err); end
        cs = 1'b1; rd = 1'b1; addr = MB + 8;
        #1;
        nchecks++; if (rdata !== 32'd0) begin nerrs++; $display("FAIL mid_reset_cnt: got %h want 0", rdata); end
        rd = 1'b0; wr = 1'b1; addr = 32'h10; wdata = 32'hFFFF_FFFF; size = 2'b00;
        @(posedge clk);
        #1;
        cs = 1'b0; wr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ref_led = 16'd0;
        ref_err = 2'b00;
        rd_op(32'h10, v);
        nchecks++; if (v !== prev) begin nerrs++; $display("FAIL reset_drops_wr: got %h want %h", v, prev); end
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; size = 2'b00;
        addr = 32'd0; wdata = 32'd0; sw_in = 16'd0;
        ref_led = 16'd0; ref_err = 2'b00;
        for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
        test_reset();
        test_random();
        test_stores();
        test_out_of_range();
        test_rw_same_cycle();
        test_led_switch();
        test_counter();
        test_wrap();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Data-memory stage directly downstream of the pipelined CPU's memory stage. It consumes the CPU's memory address, store data and chip-select/read/write strobes, and returns read data combinationally in the same cycle for the CPU's M-to-W register. It holds a word-organised data RAM with byte/halfword/word stores, right-aligns read data for the CPU's lb/lh extraction logic, and contains a small memory-mapped I/O block:

- LED register
- synchronised switch input
- cycle counter
- sticky error status

## Interface
Parameters:
- DEPTH, 1024: RAM size in 32-bit words; must be a power of two.
- MMIO_BASE, 32'h0000_FF00: byte base address of the 16-byte I/O window.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all I/O registers.
- cs  in  1  chip select (DM_CS_M).
- rd  in  1  read strobe (DM_R_M).
- wr  in  1  write strobe (DM_W_M).
- size  in  2  store width: 00 word, 01 byte, 10 halfword, 11 reserved (treated as word).
- addr  in  32  byte address (maddr).
- wdata  in  32  store data, right-aligned (mwdata).
- sw_in  in  16  asynchronous board switches.
- rdata  out  32  read data, combinational (mr_data_M).
- led  out  16  LED register.
- err  out  2  sticky status: bit0 misaligned, bit1 out-of-range.

## Operation
- Address decode, in priority order:
  - MMIO if addr[31:4] == MMIO_BASE[31:4].
  - RAM if addr < DEPTH*4.
  - Otherwise out-of-range.
- RAM index = addr[log2(DEPTH)+1:2].
- Alignment:
  - A word access needs addr[1:0]==0.
  - A halfword access needs addr[0]==0.
  - Bytes are always aligned.
  - Alignment is checked on writes only. Reads are never faulted.
- Stores (cs & wr & aligned & RAM):
  - word: writes all 4 lanes.
  - halfword: wdata[15:0] goes to lanes {addr[1],0}..{addr[1],1}.
  - byte: wdata[7:0] goes to lane addr[1:0].
  - Other lanes are unchanged.
- Reads (cs & rd):
  - RAM: rdata = mem[index] >> (8*addr[1:0]), zero-filled.
  - Out-of-range: rdata = 0.
  - Not (cs & rd): rdata = 0.
- MMIO registers, selected by offset addr[3:2]; stores to MMIO ignore size and use full wdata:
  - 0: led. Read/write. Write loads wdata[15:0]. Read returns {16'b0, led}.
  - 1: switches. Read-only. Returns {16'b0, sw_sync}, where sw_sync is the output of a 2-flop synchroniser. Writes are ignored.
  - 2: cycle counter, 32-bit, free-running, wraps at 2^32-1 to 0. Read returns the current value. A write clears it to 0.
  - 3: status. Reads {30'b0, err}. Writing 1 to a bit clears it (W1C).
- Error setting:
  - A misaligned RAM store sets err[0]; the store is suppressed.
  - A write or read to an out-of-range address sets err[1]; a write is suppressed.
  - If a W1C clear and a new error event on the same bit coincide, the set wins.
- RAM contents are not reset and are undefined until written. A testbench may preload them.

## Timing
- Reads are combinational, with 0-cycle latency from addr/cs/rd to rdata.
- Writes commit on the rising edge where cs & wr are high.
- A read of the same address in the same cycle returns the old value. From the next cycle it returns the new value.
- cs, rd and wr high together: rdata shows the pre-write value and the write commits at the edge.
- Counter: holds N in the cycle it is read; the next cycle reads N+1. After a write-clear edge it reads 0, then increments by 1 per cycle.
- Switch latency: a change on sw_in is visible on rdata at offset 1 after exactly 2 rising edges.
- Reset (asynchronous, immediate):
  - led=0, counter=0, err=0, synchroniser=0; rdata follows the decode.
  - A write coincident with reset assertion is dropped.
  - The counter resumes from 0 on the first edge after deassertion.

## Test plan
- Word store 32'hDEADBEEF to 0x10, then byte read at 0x13 -> rdata 32'h000000DE. Halfword read at 0x12 -> 32'h0000DEAD.
- Byte store 8'h5A at 0x11 over 32'h11223344 at 0x10 -> word read 32'h11225A44. Halfword store 16'hBEEF at 0x12 -> 32'hBEEF5A44.
- Halfword store at 0x21 -> RAM unchanged, err=01. Write 1 to MMIO_BASE+0xC -> err=00.
- Store to addr DEPTH*4 -> no RAM change, err=10, rdata 0 on a read there. Simultaneous W1C clear and new error event -> err bit stays 1.
- Write 32'h0000ABCD to MMIO_BASE -> led=16'hABCD. Toggle sw_in to 16'h00F0 -> offset 4 reads 16'h00F0 two edges later, not one.
- Write MMIO_BASE+8, then read it on 3 consecutive cycles -> 0, 1, 2. Assert reset mid-run with led and err nonzero -> all cleared immediately. Counter wrap from 32'hFFFFFFFF -> 0.
